// File: rtl/mmio_pkg.sv
// Shared constants for the MEM-stage MMIO bridge: IO register offsets,
// STATUS bit positions and the default IO window base.
package mmio_pkg;

  localparam logic [1:0] REG_GPI    = 2'd0;
  localparam logic [1:0] REG_GPO    = 2'd1;
  localparam logic [1:0] REG_TIMER  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int ST_EXP = 0;
  localparam int ST_CHG = 1;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_0800;

endpackage

// File: rtl/mmio_bridge_if.sv
// MEM-stage load/store bus between the pipeline (master) and the MMIO bridge (slave).
interface mmio_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  // No valid/ready pair. mem_we and mem_re qualify addr/wd for exactly the
  // current cycle. A store commits at the next rising edge. rd_data is
  // combinational and valid in the same cycle as mem_re; it is 0 otherwise.
  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output mem_we,
    output mem_re,
    output addr,
    output wd,
    input  rd_data
  );

  modport slave (
    input  mem_we,
    input  mem_re,
    input  addr,
    input  wd,
    output rd_data
  );

endinterface

// File: rtl/mmio_bridge_sync_2ff.sv
// Two-flop synchronizer for the asynchronous board inputs; both stages reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mmio_bridge.sv
// MEM-stage address decoder and IO register block (GPI, GPO, countdown timer,
// sticky W1C status). Produces the merged load word for the write-back mux.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    GPI_WIDTH  = 16,
  parameter int                    GPO_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_bridge_if.slave          bus,
  output logic                  dmem_we,
  input  logic [DATA_WIDTH-1:0] dmem_rd,
  input  logic [GPI_WIDTH-1:0]  gpi,
  output logic [GPO_WIDTH-1:0]  gpo,
  output logic                  irq
);

  logic                  io_hit;
  logic                  io_wr;
  logic [1:0]            sel;
  logic [GPI_WIDTH-1:0]  gpi_sync;
  logic [GPI_WIDTH-1:0]  gpi_prev;
  logic [GPO_WIDTH-1:0]  gpo_q;
  logic [DATA_WIDTH-1:0] timer_q;
  logic [DATA_WIDTH-1:0] timer_next;
  logic                  timer_wr;
  logic [1:0]            status_q;
  logic [1:0]            status_set;
  logic [1:0]            status_clr;
  logic [1:0]            status_next;
  logic [DATA_WIDTH-1:0] rd_io;
  logic                  unused_addr_lsb;

  // Word select only; byte offset within a register is don't-care.
  assign unused_addr_lsb = ^bus.addr[1:0];

  assign io_hit  = (bus.addr[ADDR_WIDTH-1:4] == IO_BASE[ADDR_WIDTH-1:4]);
  assign sel     = bus.addr[3:2];
  assign io_wr   = bus.mem_we & io_hit;
  assign dmem_we = bus.mem_we & ~io_hit;

  sync_2ff #(
    .WIDTH (GPI_WIDTH)
  ) u_gpi_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpi),
    .q   (gpi_sync)
  );

  assign timer_wr = io_wr && (sel == REG_TIMER);

  always_comb begin
    timer_next = timer_q;
    if (timer_wr) begin
      timer_next = bus.wd;
    end else if (timer_q != '0) begin
      timer_next = timer_q - DATA_WIDTH'(1);
    end
  end

  // EXP fires only on a natural 1->0 decrement; a store in the same cycle
  // (including a store of 0) pre-empts it.
  always_comb begin
    status_set         = 2'b00;
    status_set[ST_EXP] = (timer_q == DATA_WIDTH'(1)) && !timer_wr;
    status_set[ST_CHG] = (gpi_sync != gpi_prev);
    status_clr         = 2'b00;
    if (io_wr && (sel == REG_STATUS)) begin
      status_clr = bus.wd[1:0];
    end
    // Set is OR'd in after the clear so a same-cycle event is never lost.
    status_next = (status_q & ~status_clr) | status_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpi_prev <= '0;
      gpo_q    <= '0;
      timer_q  <= '0;
      status_q <= 2'b00;
    end else begin
      gpi_prev <= gpi_sync;
      if (io_wr && (sel == REG_GPO)) begin
        gpo_q <= bus.wd[GPO_WIDTH-1:0];
      end
      timer_q  <= timer_next;
      status_q <= status_next;
    end
  end

  always_comb begin
    rd_io = '0;
    case (sel)
      REG_GPI:    rd_io[GPI_WIDTH-1:0] = gpi_sync;
      REG_GPO:    rd_io[GPO_WIDTH-1:0] = gpo_q;
      REG_TIMER:  rd_io                = timer_q;
      REG_STATUS: rd_io[1:0]           = status_q;
      default:    rd_io                = '0;
    endcase
  end

  // Forced to 0 when no load is in flight so X from memory never reaches write-back.
  always_comb begin
    bus.rd_data = '0;
    if (bus.mem_re) begin
      bus.rd_data = io_hit ? rd_io : dmem_rd;
    end
  end

  assign gpo = gpo_q;
  assign irq = status_q[ST_EXP] | status_q[ST_CHG];

endmodule
